ef_gpio_n_apb: RTL

Parametrised N-pin GPIO with a native APB slave. It is the successor to the fixed 8-bit GPIO and adds:
- configurable pin count;
- an N-stage input synchroniser and per-pin glitch filter;
- atomic set/clear/toggle writes;
- per-pin edge/level/polarity interrupt modes, with a sticky W1C status and a registered IRQ.

It sits between the SoC APB fabric and the pad ring.

---
 rtl/ef_gpio_n_apb_if.sv | 25 ++
 rtl/ef_gpio_n_apb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ef_gpio_n_apb_if.sv
// APB3 signal bundle between the SoC fabric (master) and the GPIO block (slave).
// Handshake: a transfer is selected by PSEL; the cycle with PSEL=1 and PENABLE=0
// is the setup phase and the following cycle with PSEL=1 and PENABLE=1 is the
// access phase. PREADY is held at 1, so every access phase completes on its
// first clock edge. Writes commit on that edge, and read data is valid for the
// whole access phase.
interface ef_gpio_n_apb_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/ef_gpio_n_apb.sv
// N-pin GPIO with an APB slave: input synchroniser, per-pin glitch filter,
// atomic set/clear/toggle of the output data, and per-pin edge/level
// interrupts with a sticky write-1-to-clear status and a registered IRQ.
module ef_gpio_n_apb #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FLT_DEPTH   = 4
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  ef_gpio_n_apb_if.slave       apb,
  input  logic [N-1:0]         io_in,
  output logic [N-1:0]         io_out,
  output logic [N-1:0]         io_oe,
  output logic                 IRQ
);

  localparam int CW = $clog2(FLT_DEPTH);

  // Register offsets, decoded from PADDR[5:2].
  localparam logic [3:0] A_DATAI = 4'h0;
  localparam logic [3:0] A_DATAO = 4'h1;
  localparam logic [3:0] A_DIR   = 4'h2;
  localparam logic [3:0] A_SET   = 4'h3;
  localparam logic [3:0] A_CLR   = 4'h4;
  localparam logic [3:0] A_TGL   = 4'h5;
  localparam logic [3:0] A_IEDGE = 4'h6;
  localparam logic [3:0] A_IPOL  = 4'h7;
  localparam logic [3:0] A_IBOTH = 4'h8;
  localparam logic [3:0] A_IM    = 4'h9;
  localparam logic [3:0] A_RIS   = 4'hA;
  localparam logic [3:0] A_MIS   = 4'hB;
  localparam logic [3:0] A_ICR   = 4'hC;
  localparam logic [3:0] A_FLTEN = 4'hD;

  logic [3:0]   addr;
  logic         wr_en;
  logic         rd_en;
  logic [N-1:0] wdata;
  logic         unused_bus_bits;

  assign addr  = apb.PADDR[5:2];
  assign wr_en = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_en = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
  assign wdata = apb.PWDATA[N-1:0];
  // Address bits outside [5:2] and data bits above N are ignored by design.
  assign unused_bus_bits = ^{apb.PADDR[31:6], apb.PADDR[1:0], apb.PWDATA};

  logic [N-1:0]  sync_d [SYNC_STAGES];
  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  sync_s;
  logic [CW-1:0] cnt_d  [N];
  logic [CW-1:0] cnt_q  [N];
  logic [N-1:0]  filt_d, filt_q;
  logic [N-1:0]  prev_d, prev_q;
  logic [N-1:0]  datao_d, datao_q;
  logic [N-1:0]  dir_d, dir_q;
  logic [N-1:0]  iedge_d, iedge_q;
  logic [N-1:0]  ipol_d, ipol_q;
  logic [N-1:0]  iboth_d, iboth_q;
  logic [N-1:0]  im_d, im_q;
  logic [N-1:0]  flten_d, flten_q;
  logic [N-1:0]  ris_d, ris_q;
  logic [N-1:0]  icr_clr;
  logic [N-1:0]  rise, fall, set_cond;
  logic          irq_d, irq_q;
  logic [31:0]   prdata_d, prdata_q;

  // Zero-extend an N-bit register onto the 32-bit read bus.
  function automatic logic [31:0] ext(input logic [N-1:0] v);
    logic [31:0] r;
    r        = '0;
    r[N-1:0] = v;
    return r;
  endfunction

  // Synchroniser chain: stage 0 samples the pads, each later stage the one before.
  always_comb begin
    sync_d[0] = io_in;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
  end
  assign sync_s = sync_q[SYNC_STAGES-1];

  // Register-file writes, including the atomic set/clear/toggle forms of DATAO.
  always_comb begin
    datao_d = datao_q;
    dir_d   = dir_q;
    iedge_d = iedge_q;
    ipol_d  = ipol_q;
    iboth_d = iboth_q;
    im_d    = im_q;
    flten_d = flten_q;
    icr_clr = '0;
    if (wr_en) begin
      case (addr)
        A_DATAO: datao_d = wdata;
        A_DIR:   dir_d   = wdata;
        A_SET:   datao_d = datao_q | wdata;
        A_CLR:   datao_d = datao_q & ~wdata;
        A_TGL:   datao_d = datao_q ^ wdata;
        A_IEDGE: iedge_d = wdata;
        A_IPOL:  ipol_d  = wdata;
        A_IBOTH: iboth_d = wdata;
        A_IM:    im_d    = wdata;
        A_ICR:   icr_clr = wdata;
        A_FLTEN: flten_d = wdata;
        default: ;
      endcase
    end
  end

  // Glitch filter: a differing input must persist FLT_DEPTH samples to be taken.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = cnt_q[i];
      if (!flten_q[i]) begin
        filt_d[i] = sync_s[i];
        cnt_d[i]  = '0;
      end else if (sync_s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(FLT_DEPTH - 1)) begin
        filt_d[i] = sync_s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      // Changing a pin's filter enable restarts its count but leaves filt alone.
      if (flten_d[i] != flten_q[i]) cnt_d[i] = '0;
    end
  end

  // Interrupt detection: sticky status where a new set beats a same-cycle clear.
  always_comb begin
    prev_d   = filt_q;
    rise     = filt_q & ~prev_q;
    fall     = ~filt_q & prev_q;
    set_cond = (iedge_q & ((iboth_q & (rise | fall)) |
                           (~iboth_q & ipol_q & rise) |
                           (~iboth_q & ~ipol_q & fall))) |
               (~iedge_q & ~(filt_q ^ ipol_q));
    ris_d    = (ris_q & ~icr_clr) | set_cond;
    irq_d    = |(ris_q & im_q);
  end

  // Read mux, captured in the setup phase so data is stable for the access phase.
  always_comb begin
    prdata_d = prdata_q;
    if (rd_en) begin
      case (addr)
        A_DATAI: prdata_d = ext(filt_q);
        A_DATAO: prdata_d = ext(datao_q);
        A_DIR:   prdata_d = ext(dir_q);
        A_IEDGE: prdata_d = ext(iedge_q);
        A_IPOL:  prdata_d = ext(ipol_q);
        A_IBOTH: prdata_d = ext(iboth_q);
        A_IM:    prdata_d = ext(im_q);
        A_RIS:   prdata_d = ext(ris_q);
        A_MIS:   prdata_d = ext(ris_q & im_q);
        A_FLTEN: prdata_d = ext(flten_q);
        default: prdata_d = '0;
      endcase
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      filt_q   <= '0;
      prev_q   <= '0;
      datao_q  <= '0;
      dir_q    <= '0;
      iedge_q  <= '0;
      ipol_q   <= '0;
      iboth_q  <= '0;
      im_q     <= '0;
      flten_q  <= '0;
      ris_q    <= '0;
      irq_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      filt_q   <= filt_d;
      prev_q   <= prev_d;
      datao_q  <= datao_d;
      dir_q    <= dir_d;
      iedge_q  <= iedge_d;
      ipol_q   <= ipol_d;
      iboth_q  <= iboth_d;
      im_q     <= im_d;
      flten_q  <= flten_d;
      ris_q    <= ris_d;
      irq_q    <= irq_d;
      prdata_q <= prdata_d;
    end
  end

  assign io_out     = datao_q;
  assign io_oe      = dir_q;
  assign IRQ        = irq_q;
  assign apb.PRDATA = prdata_q;
  assign apb.PREADY = 1'b1;

endmodule
